// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, sequencer state encoding, datapath width.
package lapido_defs;
  localparam int WIDTH = 32;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOT   = 5'd5;
  localparam logic [4:0] ALU_SLL   = 5'd6;
  localparam logic [4:0] ALU_SRL   = 5'd7;
  localparam logic [4:0] ALU_SRA   = 5'd8;
  localparam logic [4:0] ALU_SLT   = 5'd9;
  localparam logic [4:0] ALU_SLTU  = 5'd10;
  localparam logic [4:0] ALU_PASSB = 5'd11;
  localparam logic [4:0] ALU_MUL   = 5'd12;
  localparam logic [4:0] ALU_MULH  = 5'd13;
  localparam logic [4:0] ALU_DIV   = 5'd14;
  localparam logic [4:0] ALU_REM   = 5'd15;
  localparam logic [4:0] ALU_DIVU  = 5'd16;
  localparam logic [4:0] ALU_REMU  = 5'd17;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic isMultiCycle(input logic [4:0] op);
    return op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU};
  endfunction
endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, plus flush and stall.
interface ex_stage_if;
  import lapido_defs::*;
  logic             flush;
  logic [WIDTH-1:0] registerFileDataA;
  logic [WIDTH-1:0] registerFileDataB;
  logic [3:0]       registerFileWrite;
  logic [WIDTH-1:0] extendedSignal;
  logic [4:0]       ALUOp;
  logic             ALUSrc;
  logic             memRead, memWrite, memToReg, regWrite;
  logic             stall;
  logic [WIDTH-1:0] aluResult;
  logic [WIDTH-1:0] storeData;
  logic [3:0]       registerFileWrite_out;
  logic             memRead_out, memWrite_out, memToReg_out, regWrite_out;
  logic             aluZero;

  modport master (
    output flush, registerFileDataA, registerFileDataB, registerFileWrite, extendedSignal,
           ALUOp, ALUSrc, memRead, memWrite, memToReg, regWrite,
    input  stall, aluResult, storeData, registerFileWrite_out,
           memRead_out, memWrite_out, memToReg_out, regWrite_out, aluZero
  );
  modport slave (
    input  flush, registerFileDataA, registerFileDataB, registerFileWrite, extendedSignal,
           ALUOp, ALUSrc, memRead, memWrite, memToReg, regWrite,
    output stall, aluResult, storeData, registerFileWrite_out,
           memRead_out, memWrite_out, memToReg_out, regWrite_out, aluZero
  );
endinterface

// File: rtl/ex_stage_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, sign-fixed in DONE.
module muldiv_seq
  import lapido_defs::*;
#(
  parameter int ITER = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(ITER);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi, lo, bReg;
  logic             isMul, isHigh, isRem, negRes, negRem, divZero;

  logic             signedOp, aNeg, bNeg;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic [2*WIDTH-1:0] prodS;

  assign signedOp = op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
  assign aNeg     = signedOp & a[WIDTH-1];
  assign bNeg     = signedOp & b[WIDTH-1];

  // lo holds multiplier (mul) or dividend/quotient (div); hi accumulates product-high / remainder
  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, bReg} : '0);
  assign shifted = {hi, lo[WIDTH-1]};
  assign diff    = shifted[WIDTH-1:0] - bReg;

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      bReg    <= '0;
      isMul   <= 1'b0;
      isHigh  <= 1'b0;
      isRem   <= 1'b0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      divZero <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          hi      <= '0;
          lo      <= aNeg ? -a : a;
          bReg    <= bNeg ? -b : b;
          isMul   <= (op == ALU_MUL) || (op == ALU_MULH);
          isHigh  <= op == ALU_MULH;
          isRem   <= (op == ALU_REM) || (op == ALU_REMU);
          negRes  <= aNeg ^ bNeg;
          negRem  <= aNeg;
          divZero <= b == '0;
          count   <= '0;
          state   <= ST_BUSY;
        end
        ST_BUSY: begin
          if (isMul) begin
            hi <= sum[WIDTH:1];
            lo <= {sum[0], lo[WIDTH-1:1]};
          end else if (shifted >= {1'b0, bReg}) begin
            hi <= diff;
            lo <= {lo[WIDTH-2:0], 1'b1};
          end else begin
            hi <= shifted[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(ITER-1)) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy  = state == ST_BUSY;
  assign done  = state == ST_DONE;
  assign prodS = negRes ? -{hi, lo} : {hi, lo};

  // divide-by-zero bypasses the sign fix so signed and unsigned both give all ones
  always_comb begin
    result = '0;
    if (isMul)        result = isHigh ? prodS[2*WIDTH-1:WIDTH] : prodS[WIDTH-1:0];
    else if (isRem)   result = negRem ? -hi : hi;
    else if (divZero) result = '1;
    else              result = negRes ? -lo : lo;
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, multi-cycle mul/div sequencer, and the EX/MEM register.
module ex_stage
  import lapido_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic       clock,
  input logic       reset,
  ex_stage_if.slave bus
);
  logic [WIDTH-1:0] opA, opB, aluOut, seqResult, nextResult;
  logic             isMulti, seqBusy, seqDone, bubble;

  assign opA     = bus.registerFileDataA;
  assign opB     = bus.ALUSrc ? bus.extendedSignal : bus.registerFileDataB;
  assign isMulti = isMultiCycle(bus.ALUOp);

  always_comb begin
    aluOut = '0;
    case (bus.ALUOp)
      ALU_ADD:   aluOut = opA + opB;
      ALU_SUB:   aluOut = opA - opB;
      ALU_AND:   aluOut = opA & opB;
      ALU_OR:    aluOut = opA | opB;
      ALU_XOR:   aluOut = opA ^ opB;
      ALU_NOT:   aluOut = ~opA;
      ALU_SLL:   aluOut = opA << opB[4:0];
      ALU_SRL:   aluOut = opA >> opB[4:0];
      ALU_SRA:   aluOut = $signed(opA) >>> opB[4:0];
      ALU_SLT:   aluOut = {{(WIDTH-1){1'b0}}, $signed(opA) < $signed(opB)};
      ALU_SLTU:  aluOut = {{(WIDTH-1){1'b0}}, opA < opB};
      ALU_PASSB: aluOut = opB;
      default:   aluOut = '0;
    endcase
  end

  muldiv_seq #(.ITER(ITER)) seq (
    .clock  (clock),
    .reset  (reset),
    .flush  (bus.flush),
    .start  (isMulti),
    .op     (bus.ALUOp),
    .a      (opA),
    .b      (opB),
    .busy   (seqBusy),
    .done   (seqDone),
    .result (seqResult)
  );

  // DONE is the only state where a multi-cycle op is allowed past EX/MEM
  assign bus.stall  = (isMulti && !seqBusy && !seqDone) || seqBusy;
  assign bubble     = bus.flush || (isMulti && !seqDone);
  assign nextResult = seqDone ? seqResult : aluOut;

  always_ff @(negedge clock or posedge reset) begin
    if (reset || bubble) begin
      bus.aluResult             <= '0;
      bus.storeData             <= '0;
      bus.registerFileWrite_out <= '0;
      bus.memRead_out           <= 1'b0;
      bus.memWrite_out          <= 1'b0;
      bus.memToReg_out          <= 1'b0;
      bus.regWrite_out          <= 1'b0;
      bus.aluZero               <= 1'b0;
    end else begin
      bus.aluResult             <= nextResult;
      bus.storeData             <= bus.registerFileDataB;
      bus.registerFileWrite_out <= bus.registerFileWrite;
      bus.memRead_out           <= bus.memRead;
      bus.memWrite_out          <= bus.memWrite;
      bus.memToReg_out          <= bus.memToReg;
      bus.regWrite_out          <= bus.regWrite;
      bus.aluZero               <= nextResult == '0;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: driver pushes expectations, monitor pops on every non-bubble EX/MEM output.
module tb_ex_stage;
  import lapido_defs::*;

  logic clock = 1'b0;
  logic reset;
  ex_stage_if bus ();
  ex_stage dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] sd;
    logic [3:0]  rd;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [3:0] ctrlOut();
    return {bus.memRead_out, bus.memWrite_out, bus.memToReg_out, bus.regWrite_out};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: any output carrying a control bit is a retired instruction
  always @(posedge clock) begin
    exp_t e;
    if (!reset && ctrlOut() != 4'b0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output got res=%h ctrl=%b exp none", bus.aluResult, ctrlOut());
      end else begin
        e = sb.pop_front();
        check({e.name, ":result"}, bus.aluResult, e.res);
        check({e.name, ":storeData"}, bus.storeData, e.sd);
        check({e.name, ":rd"}, 32'(bus.registerFileWrite_out), 32'(e.rd));
        check({e.name, ":ctrl"}, 32'(ctrlOut()), 32'(e.ctrl));
        check({e.name, ":zero"}, 32'(bus.aluZero), 32'(e.res == 32'd0));
      end
    end
  end

  task automatic setIn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [3:0] rd,
                       input logic [3:0] ctrl);
    bus.ALUOp             = op;
    bus.registerFileDataA = a;
    bus.registerFileDataB = b;
    bus.extendedSignal    = imm;
    bus.ALUSrc            = src;
    bus.registerFileWrite = rd;
    {bus.memRead, bus.memWrite, bus.memToReg, bus.regWrite} = ctrl;
  endtask

  task automatic nop();
    setIn(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 4'd0, 4'b0000);
  endtask

  // Entered and left at posedge+2; the instruction is captured at the following negedge(s)
  task automatic runOp(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic src,
                       input logic [3:0] rd, input logic [3:0] ctrl, input logic [31:0] res,
                       input bit multi);
    int n;
    int bubBad;
    sb.push_back('{name, res, b, rd, ctrl});
    setIn(op, a, b, imm, src, rd, ctrl);
    #1;
    n = 0;
    bubBad = 0;
    while (bus.stall && n < 40) begin
      n++;
      if (n > 1 && (ctrlOut() != 4'b0 || bus.aluResult != 32'd0)) bubBad++;
      @(posedge clock);
      #3;
    end
    check({name, ":stall_cycles"}, 32'(n), multi ? 32'd33 : 32'd0);
    if (multi) check({name, ":bubbles"}, 32'(bubBad), 32'd0);
    @(posedge clock);
    #2;
    check({name, ":latency"}, 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0;
    nop();
    #12;
    check("reset:result", bus.aluResult, 32'd0);
    check("reset:ctrl", 32'(ctrlOut()), 32'd0);
    check("reset:stall", 32'(bus.stall), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    // single-cycle ops, back to back
    runOp("add_imm",  ALU_ADD,   32'd5,        32'd0,        32'hFFFFFFFD, 1'b1, 4'd3, 4'b0001, 32'd2,        1'b0);
    runOp("sra",      ALU_SRA,   32'h80000000, 32'd4,        32'd0,        1'b0, 4'd4, 4'b0001, 32'hF8000000, 1'b0);
    runOp("sltu",     ALU_SLTU,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 4'd5, 4'b0001, 32'd1,        1'b0);
    runOp("slt",      ALU_SLT,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 4'd5, 4'b0001, 32'd0,        1'b0);
    runOp("sub_zero", ALU_SUB,   32'd5,        32'd5,        32'd0,        1'b0, 4'd6, 4'b0001, 32'd0,        1'b0);
    runOp("store",    ALU_ADD,   32'h1000,     32'hCAFEBABE, 32'd8,        1'b1, 4'd0, 4'b0100, 32'h1008,     1'b0);
    runOp("load",     ALU_ADD,   32'h2000,     32'd0,        32'hC,        1'b1, 4'd7, 4'b1011, 32'h200C,     1'b0);
    runOp("not",      ALU_NOT,   32'd0,        32'd0,        32'd0,        1'b0, 4'd8, 4'b0001, 32'hFFFFFFFF, 1'b0);
    runOp("sll31",    ALU_SLL,   32'd1,        32'h3F,       32'd0,        1'b0, 4'd9, 4'b0001, 32'h80000000, 1'b0);
    runOp("srl",      ALU_SRL,   32'h80000000, 32'd4,        32'd0,        1'b0, 4'd9, 4'b0001, 32'h08000000, 1'b0);
    runOp("and",      ALU_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 4'd1, 4'b0001, 32'hF000F000, 1'b0);
    runOp("or",       ALU_OR,    32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 4'd1, 4'b0001, 32'hFFF0FFF0, 1'b0);
    runOp("xor",      ALU_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 4'd1, 4'b0001, 32'h0FF00FF0, 1'b0);
    runOp("passb",    ALU_PASSB, 32'h1234,     32'd0,        32'hABCD,     1'b1, 4'd2, 4'b0001, 32'h0000ABCD, 1'b0);
    runOp("op20",     5'd20,     32'd5,        32'd5,        32'd0,        1'b0, 4'd9, 4'b0001, 32'd0,        1'b0);

    // multi-cycle ops
    runOp("mul",      ALU_MUL,   32'hFFFFFFFF, 32'd2,        32'd0, 1'b0, 4'd10, 4'b0001, 32'hFFFFFFFE, 1'b1);
    runOp("mulh",     ALU_MULH,  32'hFFFFFFFF, 32'd2,        32'd0, 1'b0, 4'd10, 4'b0001, 32'hFFFFFFFF, 1'b1);
    runOp("mulh_min", ALU_MULH,  32'h80000000, 32'h80000000, 32'd0, 1'b0, 4'd10, 4'b0001, 32'h40000000, 1'b1);
    runOp("div",      ALU_DIV,   32'hFFFFFFF9, 32'd2,        32'd0, 1'b0, 4'd11, 4'b0001, 32'hFFFFFFFD, 1'b1);
    runOp("rem",      ALU_REM,   32'hFFFFFFF9, 32'd2,        32'd0, 1'b0, 4'd11, 4'b0001, 32'hFFFFFFFF, 1'b1);
    runOp("divu_z",   ALU_DIVU,  32'd100,      32'd0,        32'd0, 1'b0, 4'd12, 4'b0001, 32'hFFFFFFFF, 1'b1);
    runOp("remu_z",   ALU_REMU,  32'd100,      32'd0,        32'd0, 1'b0, 4'd12, 4'b0001, 32'd100,      1'b1);
    runOp("div_z",    ALU_DIV,   32'hFFFFFFF9, 32'd0,        32'd0, 1'b0, 4'd13, 4'b0001, 32'hFFFFFFFF, 1'b1);
    runOp("rem_z",    ALU_REM,   32'hFFFFFFF9, 32'd0,        32'd0, 1'b0, 4'd13, 4'b0001, 32'hFFFFFFF9, 1'b1);
    runOp("div_ovf",  ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 4'd14, 4'b0001, 32'h80000000, 1'b1);
    runOp("rem_ovf",  ALU_REM,   32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 4'd14, 4'b0001, 32'd0,        1'b1);
    nop();

    // flush mid-divide
    @(posedge clock);
    #2;
    setIn(ALU_DIV, 32'd100, 32'd3, 32'd0, 1'b0, 4'd1, 4'b0001);
    #1;
    repeat (10) begin
      @(posedge clock);
      #3;
    end
    check("flush_pre:stall", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    @(posedge clock);
    #2;
    bus.flush = 1'b0;
    nop();
    #1;
    check("flush_post:stall", 32'(bus.stall), 32'd0);
    check("flush_post:ctrl", 32'(ctrlOut()), 32'd0);
    check("flush_post:result", bus.aluResult, 32'd0);
    @(posedge clock);
    #2;
    runOp("add_after_flush", ALU_ADD, 32'd40, 32'd2, 32'd0, 1'b0, 4'd6, 4'b0001, 32'd42, 1'b0);

    // flush together with a multi-cycle op in IDLE must not start it
    setIn(ALU_MUL, 32'd3, 32'd3, 32'd0, 1'b0, 4'd1, 4'b0001);
    bus.flush = 1'b1;
    @(posedge clock);
    #2;
    bus.flush = 1'b0;
    nop();
    #1;
    check("flush_idle:stall", 32'(bus.stall), 32'd0);
    @(posedge clock);
    #2;

    // reset clears a live EX/MEM output immediately
    runOp("add_pre_reset", ALU_ADD, 32'd7, 32'd0, 32'd1, 1'b1, 4'd2, 4'b0001, 32'd8, 1'b0);
    reset = 1'b1;
    nop();
    #1;
    check("reset_async:result", bus.aluResult, 32'd0);
    check("reset_async:ctrl", 32'(ctrlOut()), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;

    // reset mid-multiply discards the op
    setIn(ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 4'd3, 4'b0001);
    #1;
    repeat (10) begin
      @(posedge clock);
      #3;
    end
    reset = 1'b1;
    nop();
    #1;
    check("reset_mid:stall", 32'(bus.stall), 32'd0);
    check("reset_mid:result", bus.aluResult, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    runOp("add_after_reset", ALU_ADD, 32'd9, 32'd1, 32'd0, 1'b0, 4'd4, 4'b0001, 32'd10, 1'b0);
    nop();
    repeat (3) @(posedge clock);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage and EX/MEM pipeline register. It consumes the ID/EX register outputs, computes the ALU result and registers it, with store data and control, for the MEM stage.
- Single-cycle ops complete in one clock.
- MUL/MULH/DIV/DIVU/REM/REMU run on a 32-iteration shift-add/restoring sequencer. While it runs, `stall` holds the upstream pipeline registers.

Parameters:
- WIDTH, 32, datapath width; must be 32, fixed by the encodings below.
- ITER, 32, iterations per multi-cycle op; must equal WIDTH.

Ports:
- clock  input  1  pipeline clock; all state updates on its falling edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- flush  input  1  sampled at the edge; aborts any op and injects a bubble.
- registerFileDataA  input  32  operand A.
- registerFileDataB  input  32  operand B source / store data.
- registerFileWrite  input  4  destination register.
- extendedSignal  input  32  immediate.
- ALUOp  input  5  operation code.
- ALUSrc  input  1  1: B = extendedSignal, 0: B = registerFileDataB.
- memRead, memWrite, memToReg, regWrite  input  1 each  control bits to forward.
- stall  output  1  combinational; 1 = upstream must hold.
- aluResult  output  32  registered result.
- storeData  output  32  registered registerFileDataB.
- registerFileWrite_out  output  4  registered destination.
- memRead_out, memWrite_out, memToReg_out, regWrite_out  output  1 each  registered control.
- aluZero  output  1  registered (result == 0).

Behaviour:
- Reset (async):
  - All registered outputs go to 0 and the FSM goes to IDLE with count = 0.
  - stall is 0 after reset.
  - Reset mid-operation discards the op with no output.
- Operand B = ALUSrc ? extendedSignal : registerFileDataB.
- ALUOp encodings:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SLL, 7 SRL, 8 SRA; shift amount is B[4:0].
  - 9 SLT (signed), 10 SLTU, 11 PASSB.
  - 12 MUL (low 32), 13 MULH (signed high 32).
  - 14 DIV, 15 REM, 16 DIVU, 17 REMU.
  - 18–31 give result 0; control still forwarded.
- ADD/SUB wrap modulo 2^32; no flags besides aluZero.
- Single-cycle ops (ALUOp < 12 or > 17): latency 1 edge; EX/MEM captures result, controls and storeData.
- FSM states: IDLE, BUSY, DONE.
- IDLE, multi-cycle op, no flush:
  - Latch operand magnitudes and sign info; count ← 0; go to BUSY.
  - EX/MEM loads a bubble: all four control outputs 0, data 0.
- BUSY: one iteration per edge, count++. The edge that completes iteration 31 moves to DONE. EX/MEM keeps loading bubbles.
- DONE:
  - Apply sign fix; EX/MEM captures the final result with the instruction's controls; go to IDLE.
  - The upstream register loads the next instruction on the same edge.
- stall = (IDLE & multi-cycle op) | BUSY. It is 0 in DONE.
- Total latency is 34 edges, with stall high for 33 cycles.
- Signed ops work on magnitudes:
  - Negate quotient/product if the operand signs differ.
  - Remainder takes the dividend's sign.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend. Signed and unsigned behave the same.
- 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0.
- flush has priority over all transitions:
  - FSM goes to IDLE, EX/MEM loads a bubble, stall drops in the next cycle.
  - flush together with a multi-cycle op in IDLE does not start the op.

Decomposition:
- Shared package `lapido_defs`: ALUOp encodings (ALU_ADD … ALU_REMU), FSM state encoding, WIDTH.
- One sub-module, `muldiv_seq`: iterative multiply/divide sequencer with start/busy/done and a flush input.
- ALU combinational logic and the EX/MEM register stay in `ex_stage`.

Test Plan:
- A=5, B=imm 0xFFFFFFFD, ALUSrc=1, ADD, regWrite=1 -> after 1 edge: aluResult=2, regWrite_out=1, aluZero=0, stall never 1.
- SRA A=0x80000000, B=4 -> 0xF8000000. SLTU A=1, B=0xFFFFFFFF -> 1. SLT with the same operands -> 0.
- MUL A=0xFFFFFFFF, B=2, regWrite=1 -> stall high 33 cycles, bubbles meanwhile, then aluResult=0xFFFFFFFE and regWrite_out=1 on edge 34. MULH with the same operands -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> quotient -3. REM -> -1. DIVU with B=0 -> 0xFFFFFFFF. REMU with B=0 -> A.
- Start DIV, assert flush at cycle 10 -> stall drops next cycle, outputs are a bubble, a following ADD completes normally. Repeat the test using reset instead of flush: all outputs 0 immediately.
- memWrite=1, registerFileDataB=0xCAFEBABE, ADD base -> storeData=0xCAFEBABE, memWrite_out=1 after 1 edge.
